// File: rtl/elevator_floor_display.sv
// Floor-position display: synchronises and debounces one-hot cabin sensors, classifies the cabin
// position, tracks floor/direction/error history and drives one active-low 7-segment digit.
module elevator_floor_display #(
  parameter int N_FLOORS        = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] floor_sense,
  output logic [6:0]          HEX0,
  output logic [3:0]          current_floor,
  output logic                at_floor,
  output logic                error,
  output logic [1:0]          dir,
  output logic [7:0]          error_count
);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_AT_FLOOR = 2'd1,
    ST_BETWEEN  = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  localparam logic [7:0] DEB_MAX  = 8'(DEBOUNCE_CYCLES);
  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_H    = 7'b0001001;
  localparam logic [6:0] SEG_E    = 7'b0000110;

  logic [N_FLOORS-1:0] s1, s2, stable;
  logic [1:0]          sync_valid;
  logic [7:0]          deb_cnt;
  logic                accept;

  state_t     state, state_next;
  logic [3:0] last_floor, last_floor_next;
  logic [1:0] dir_q, dir_next;
  logic [7:0] ecnt_q, ecnt_next;

  logic [3:0] pop;
  logic [3:0] floor_idx;

  // sync_valid marks when s2 holds a real post-reset sample, so the first
  // acceptance after reset takes the full synchroniser plus debounce latency.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1         <= '0;
      s2         <= '0;
      sync_valid <= 2'b00;
    end else begin
      s1         <= floor_sense;
      s2         <= s1;
      sync_valid <= {sync_valid[0], 1'b1};
    end
  end

  // A count of zero means no sample has been taken since reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      deb_cnt <= 8'd0;
      stable  <= '0;
    end else if (sync_valid[1]) begin
      if (deb_cnt == 8'd0 || s2 != stable) begin
        deb_cnt <= 8'd1;
        stable  <= s2;
      end else if (deb_cnt != DEB_MAX) begin
        deb_cnt <= deb_cnt + 8'd1;
      end
    end
  end

  assign accept = (deb_cnt == DEB_MAX);

  always_comb begin
    pop       = 4'd0;
    floor_idx = 4'd0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (stable[i]) begin
        pop       = pop + 4'd1;
        floor_idx = 4'(i);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= ST_INIT;
      last_floor <= 4'd0;
      dir_q      <= DIR_IDLE;
      ecnt_q     <= 8'd0;
    end else begin
      state      <= state_next;
      last_floor <= last_floor_next;
      dir_q      <= dir_next;
      ecnt_q     <= ecnt_next;
    end
  end

  always_comb begin
    state_next      = state;
    last_floor_next = last_floor;
    dir_next        = dir_q;
    ecnt_next       = ecnt_q;
    if (accept) begin
      if (pop == 4'd0) begin
        state_next = ST_BETWEEN;
      end else if (pop == 4'd1) begin
        state_next      = ST_AT_FLOOR;
        last_floor_next = floor_idx;
        // Re-acceptance of the same floor while parked must not clear dir.
        if (state != ST_INIT && !(state == ST_AT_FLOOR && floor_idx == last_floor)) begin
          if (floor_idx > last_floor)      dir_next = DIR_UP;
          else if (floor_idx < last_floor) dir_next = DIR_DOWN;
          else                             dir_next = DIR_IDLE;
        end
      end else begin
        state_next = ST_ERROR;
        if (state != ST_ERROR && ecnt_q != 8'hFF) ecnt_next = ecnt_q + 8'd1;
      end
    end
  end

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 7'b1000000;
      4'd1:    digit_seg = 7'b1111001;
      4'd2:    digit_seg = 7'b0100100;
      4'd3:    digit_seg = 7'b0110000;
      4'd4:    digit_seg = 7'b0011001;
      4'd5:    digit_seg = 7'b0010010;
      4'd6:    digit_seg = 7'b0000010;
      4'd7:    digit_seg = 7'b1111000;
      4'd8:    digit_seg = 7'b0000000;
      4'd9:    digit_seg = 7'b0010000;
      default: digit_seg = SEG_DASH;
    endcase
  endfunction

  // Output stage lags the state register by one edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      HEX0          <= SEG_DASH;
      current_floor <= 4'd0;
      at_floor      <= 1'b0;
      error         <= 1'b0;
      dir           <= DIR_IDLE;
      error_count   <= 8'd0;
    end else begin
      case (state)
        ST_AT_FLOOR: HEX0 <= digit_seg(last_floor);
        ST_BETWEEN:  HEX0 <= SEG_H;
        ST_ERROR:    HEX0 <= SEG_E;
        default:     HEX0 <= SEG_DASH;
      endcase
      current_floor <= last_floor;
      at_floor      <= (state == ST_AT_FLOOR);
      error         <= (state == ST_ERROR);
      dir           <= dir_q;
      error_count   <= ecnt_q;
    end
  end

endmodule

// File: tb/tb_elevator_floor_display.sv
// Directed bench for elevator_floor_display with N_FLOORS = 4, DEBOUNCE_CYCLES = 4.
module tb_elevator_floor_display;

  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_H    = 7'b0001001;
  localparam logic [6:0] SEG_E    = 7'b0000110;
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] floor_sense;
  logic [6:0] HEX0;
  logic [3:0] current_floor;
  logic       at_floor;
  logic       error;
  logic [1:0] dir;
  logic [7:0] error_count;

  int vectors = 0;
  int fails   = 0;

  elevator_floor_display #(.N_FLOORS(4), .DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .floor_sense   (floor_sense),
    .HEX0          (HEX0),
    .current_floor (current_floor),
    .at_floor      (at_floor),
    .error         (error),
    .dir           (dir),
    .error_count   (error_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic hold(input logic [3:0] v, input int n);
    floor_sense = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    floor_sense = 4'b0000;
    repeat (3) @(negedge clk);
    vectors++;
    if (HEX0 !== SEG_DASH || current_floor !== 4'd0 || at_floor !== 1'b0 ||
        error !== 1'b0 || dir !== 2'b00 || error_count !== 8'd0) begin
      fails++;
      $display("FAIL reset_values: hex=%b floor=%0d at=%b err=%b dir=%b ecnt=%0d, want hex=%b all zero",
               HEX0, current_floor, at_floor, error, dir, error_count, SEG_DASH);
    end
    reset = 1'b0;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      vectors++;
      if (HEX0 !== ((i < 7) ? SEG_DASH : SEG_H)) begin
        fails++;
        $display("FAIL first_accept_edge%0d: hex=%b want %b", i, HEX0, (i < 7) ? SEG_DASH : SEG_H);
      end
    end
    vectors++;
    if (at_floor !== 1'b0 || dir !== 2'b00 || error !== 1'b0) begin
      fails++;
      $display("FAIL first_between_flags: at=%b dir=%b err=%b want 0 00 0", at_floor, dir, error);
    end
  endtask

  task automatic test_travel_up();
    hold(4'b0001, 20);
    vectors++;
    if (HEX0 !== SEG_0 || current_floor !== 4'd0 || at_floor !== 1'b1 || dir !== 2'b00) begin
      fails++;
      $display("FAIL floor0: hex=%b floor=%0d at=%b dir=%b want %b 0 1 00", HEX0, current_floor, at_floor, dir, SEG_0);
    end
    hold(4'b0000, 20);
    vectors++;
    if (HEX0 !== SEG_H || current_floor !== 4'd0 || at_floor !== 1'b0 || dir !== 2'b00) begin
      fails++;
      $display("FAIL leave0: hex=%b floor=%0d at=%b dir=%b want %b 0 0 00", HEX0, current_floor, at_floor, dir, SEG_H);
    end
    hold(4'b0100, 20);
    vectors++;
    if (HEX0 !== SEG_2 || current_floor !== 4'd2 || at_floor !== 1'b1 || dir !== 2'b01) begin
      fails++;
      $display("FAIL arrive2: hex=%b floor=%0d at=%b dir=%b want %b 2 1 01", HEX0, current_floor, at_floor, dir, SEG_2);
    end
    hold(4'b0000, 20);
    vectors++;
    if (HEX0 !== SEG_H || current_floor !== 4'd2 || dir !== 2'b01) begin
      fails++;
      $display("FAIL leave2_hold: hex=%b floor=%0d dir=%b want %b 2 01", HEX0, current_floor, dir, SEG_H);
    end
  endtask

  task automatic test_travel_down();
    hold(4'b0010, 20);
    vectors++;
    if (HEX0 !== SEG_1 || current_floor !== 4'd1 || at_floor !== 1'b1 || dir !== 2'b10) begin
      fails++;
      $display("FAIL arrive1_down: hex=%b floor=%0d at=%b dir=%b want %b 1 1 10", HEX0, current_floor, at_floor, dir, SEG_1);
    end
  endtask

  task automatic test_glitch();
    hold(4'b0000, 20);
    hold(4'b1000, 3);
    floor_sense = 4'b0000;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      vectors++;
      if (HEX0 !== SEG_H || at_floor !== 1'b0 || current_floor !== 4'd1 || dir !== 2'b10) begin
        fails++;
        $display("FAIL glitch_cycle%0d: hex=%b at=%b floor=%0d dir=%b want %b 0 1 10",
                 i, HEX0, at_floor, current_floor, dir, SEG_H);
      end
    end
  endtask

  task automatic test_error();
    hold(4'b0011, 20);
    vectors++;
    if (HEX0 !== SEG_E || error !== 1'b1 || at_floor !== 1'b0 || error_count !== 8'd1) begin
      fails++;
      $display("FAIL error1: hex=%b err=%b at=%b ecnt=%0d want %b 1 0 1", HEX0, error, at_floor, error_count, SEG_E);
    end
    hold(4'b0001, 20);
    vectors++;
    if (HEX0 !== SEG_0 || error !== 1'b0 || current_floor !== 4'd0 || dir !== 2'b10 || error_count !== 8'd1) begin
      fails++;
      $display("FAIL error_exit: hex=%b err=%b floor=%0d dir=%b ecnt=%0d want %b 0 0 10 1",
               HEX0, error, current_floor, dir, error_count, SEG_0);
    end
    hold(4'b0011, 20);
    vectors++;
    if (HEX0 !== SEG_E || error !== 1'b1 || error_count !== 8'd2) begin
      fails++;
      $display("FAIL error2: hex=%b err=%b ecnt=%0d want %b 1 2", HEX0, error, error_count, SEG_E);
    end
  endtask

  task automatic test_saturate_and_reset();
    for (int i = 0; i < 300; i++) begin
      hold(4'b0000, 10);
      hold(4'b0011, 10);
    end
    vectors++;
    if (error_count !== 8'd255 || error !== 1'b1) begin
      fails++;
      $display("FAIL saturate: ecnt=%0d err=%b want 255 1", error_count, error);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (HEX0 !== SEG_DASH || current_floor !== 4'd0 || at_floor !== 1'b0 ||
        error !== 1'b0 || dir !== 2'b00 || error_count !== 8'd0) begin
      fails++;
      $display("FAIL mid_error_reset: hex=%b floor=%0d at=%b err=%b dir=%b ecnt=%0d want %b all zero",
               HEX0, current_floor, at_floor, error, dir, error_count, SEG_DASH);
    end
    reset = 1'b0;
    hold(4'b0011, 20);
    vectors++;
    if (HEX0 !== SEG_E || error !== 1'b1 || error_count !== 8'd1) begin
      fails++;
      $display("FAIL init_to_error: hex=%b err=%b ecnt=%0d want %b 1 1", HEX0, error, error_count, SEG_E);
    end
  endtask

  initial begin
    test_reset();
    test_travel_up();
    test_travel_down();
    test_glitch();
    test_error();
    test_saturate_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
